// File: rtl/qos_pkg.sv
// qos_pkg: shared constants and helpers for the QoS virtual-channel router.
// Holds the default geometry, the arb_mode encoding, the packet field
// position helpers and a constant-evaluable clog2.
package qos_pkg;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam int DEF_BW       = 6;
  localparam int DEF_NUM_VC   = 4;
  localparam int DEF_NUM_DEST = 4;
  localparam int DEF_VC_DEPTH = 16;
  localparam int DEF_WW       = 4;

  // Packet layout: VC id in the top bits, destination right below it.
  function automatic int vc_field_msb(input int bw);
    return bw - 1;
  endfunction

  function automatic int dst_field_msb(input int bw, input int vcw);
    return bw - 1 - vcw;
  endfunction

  typedef enum logic {
    ARB_WRR    = 1'b0,
    ARB_STRICT = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/vc_fifo.sv
// vc_fifo: show-ahead synchronous FIFO with occupancy-based status flags.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   push, din                  write request and data (dropped when full)
//   pop                        read request (ignored when empty)
//   dout                       head entry, valid whenever empty is low
//   umbral_high, umbral_low    almost-full / almost-empty thresholds
//   empty, almost_full,
//   almost_empty               combinational flags from occupancy
//   overflow                   push attempted while full (this cycle)
module vc_fifo
  import qos_pkg::*;
#(
  parameter int W     = 6,
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  input  logic [CW-1:0] umbral_high,
  input  logic [CW-1:0] umbral_low,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full         = (occ == CW'(DEPTH));
  assign empty        = (occ == '0);
  assign almost_full  = (occ >= umbral_high);
  assign almost_empty = (occ <= umbral_low);
  assign do_push      = push & ~full;
  assign do_pop       = pop & ~empty;
  assign overflow     = push & full;
  assign dout         = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together keeps occ steady.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop) begin
        occ <= occ + CW'(1);
      end else if (do_pop && !do_push) begin
        occ <= occ - CW'(1);
      end
    end
  end

endmodule

// File: rtl/qos_vc_router.sv
// qos_vc_router: routes packets into per-VC FIFOs and arbitrates one pop per
// cycle (weighted round-robin or strict priority) to a registered,
// one-hot-strobed output per destination.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_data      packet offer; in_ready when no VC is almost full
//   arb_mode              0 = weighted round-robin, 1 = strict priority
//   vc_weight             per-VC burst weight (0 behaves as 1)
//   umbral_high/low       shared almost-full / almost-empty thresholds
//   dest_almost_full      downstream backpressure per destination
//   out_valid/out_data    registered write strobe and data per destination
//   vc_almost_full/almost_empty/empty   per-VC status flags
//   error_output          sticky write-to-full error
module qos_vc_router
  import qos_pkg::*;
#(
  parameter int BW       = DEF_BW,
  parameter int NUM_VC   = DEF_NUM_VC,
  parameter int NUM_DEST = DEF_NUM_DEST,
  parameter int VC_DEPTH = DEF_VC_DEPTH,
  parameter int WW       = DEF_WW,
  localparam int CW      = clog2(VC_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [BW-1:0]          in_data,
  output logic                   in_ready,
  input  logic                   arb_mode,
  input  logic [NUM_VC*WW-1:0]   vc_weight,
  input  logic [CW-1:0]          umbral_high,
  input  logic [CW-1:0]          umbral_low,
  input  logic [NUM_DEST-1:0]    dest_almost_full,
  output logic [NUM_DEST-1:0]    out_valid,
  output logic [NUM_DEST*BW-1:0] out_data,
  output logic [NUM_VC-1:0]      vc_almost_full,
  output logic [NUM_VC-1:0]      vc_almost_empty,
  output logic [NUM_VC-1:0]      vc_empty,
  output logic                   error_output
);

  localparam int VCW     = clog2(NUM_VC);
  localparam int DSTW    = clog2(NUM_DEST);
  localparam int VC_MSB  = vc_field_msb(BW);
  localparam int DST_MSB = dst_field_msb(BW, VCW);

  logic [BW-1:0]     head      [NUM_VC];
  logic [DSTW-1:0]   head_dest [NUM_VC];
  logic [WW-1:0]     eff_w     [NUM_VC];
  logic [NUM_VC-1:0] push;
  logic [NUM_VC-1:0] pop;
  logic [NUM_VC-1:0] overflow;
  logic [NUM_VC-1:0] eligible;
  logic [VCW-1:0]    in_vc;
  logic              accept;

  logic [VCW-1:0]    ptr;
  logic [VCW-1:0]    ptr_n;
  logic [WW-1:0]     cred;
  logic [WW-1:0]     cred_n;
  logic [VCW-1:0]    gnt_idx;
  logic              gnt_any;
  logic [BW-1:0]     gnt_data;
  logic [DSTW-1:0]   gnt_dest;

  assign in_ready = ~reset & ~|vc_almost_full;
  assign accept   = in_valid & in_ready;
  assign in_vc    = in_data[VC_MSB -: VCW];

  for (genvar k = 0; k < NUM_VC; k++) begin : g_vc
    assign push[k]      = accept && (in_vc == VCW'(k));
    assign pop[k]       = gnt_any && (gnt_idx == VCW'(k));
    assign head_dest[k] = head[k][DST_MSB -: DSTW];
    assign eligible[k]  = ~vc_empty[k] & ~dest_almost_full[head_dest[k]];
    assign eff_w[k]     = (vc_weight[k*WW +: WW] == '0) ? WW'(1) : vc_weight[k*WW +: WW];

    vc_fifo #(.W(BW), .DEPTH(VC_DEPTH), .CW(CW)) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push         (push[k]),
      .din          (in_data),
      .pop          (pop[k]),
      .dout         (head[k]),
      .umbral_high  (umbral_high),
      .umbral_low   (umbral_low),
      .empty        (vc_empty[k]),
      .almost_full  (vc_almost_full[k]),
      .almost_empty (vc_almost_empty[k]),
      .overflow     (overflow[k])
    );
  end

  // First eligible VC strictly after 'from' in cyclic order; 'from' itself
  // is reached last, so a lone eligible VC finds itself.
  function automatic logic [VCW-1:0] next_after(input logic [VCW-1:0] from,
                                                input logic [NUM_VC-1:0] el);
    logic [VCW-1:0] idx;
    logic           found;
    next_after = from;
    found      = 1'b0;
    for (int i = 1; i <= NUM_VC; i++) begin
      idx = VCW'((int'(from) + i) % NUM_VC);
      if (!found && el[idx]) begin
        next_after = idx;
        found      = 1'b1;
      end
    end
  endfunction

  // Grant selection. Strict mode leaves ptr/cred untouched so switching
  // back to WRR resumes where it left off.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    ptr_n   = ptr;
    cred_n  = cred;
    if (|eligible) begin
      gnt_any = 1'b1;
      if (arb_mode_e'(arb_mode) == ARB_STRICT) begin
        for (int k = NUM_VC - 1; k >= 0; k--) begin
          if (eligible[k]) gnt_idx = VCW'(k);
        end
      end else if (eligible[ptr]) begin
        gnt_idx = ptr;
        if (({1'b0, cred} + (WW+1)'(1)) >= {1'b0, eff_w[ptr]}) begin
          cred_n = '0;
          ptr_n  = next_after(ptr, eligible);
        end else begin
          cred_n = cred + WW'(1);
        end
      end else begin
        gnt_idx = next_after(ptr, eligible);
        if (eff_w[gnt_idx] <= WW'(1)) begin
          cred_n = '0;
          ptr_n  = next_after(gnt_idx, eligible);
        end else begin
          cred_n = WW'(1);
          ptr_n  = gnt_idx;
        end
      end
    end
  end

  assign gnt_data = head[gnt_idx];
  assign gnt_dest = head_dest[gnt_idx];

  // Registered output stage plus arbiter state and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= '0;
      out_data     <= '0;
      ptr          <= '0;
      cred         <= '0;
      error_output <= 1'b0;
    end else begin
      out_valid <= '0;
      if (gnt_any) begin
        out_valid[gnt_dest]                 <= 1'b1;
        out_data[int'(gnt_dest)*BW +: BW]   <= gnt_data;
      end
      ptr  <= ptr_n;
      cred <= cred_n;
      if (|overflow) error_output <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qos_vc_router.sv
// tb_qos_vc_router: directed phases plus a randomized phase, all checked
// every cycle against a queue-based reference model of the router.
module tb_qos_vc_router;
  import qos_pkg::*;

  localparam int BW       = 6;
  localparam int NUM_VC   = 4;
  localparam int NUM_DEST = 4;
  localparam int VC_DEPTH = 16;
  localparam int WW       = 4;
  localparam int VCW      = 2;
  localparam int DSTW     = 2;
  localparam int CW       = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic [BW-1:0]          in_data;
  logic                   in_ready;
  logic                   arb_mode;
  logic [NUM_VC*WW-1:0]   vc_weight;
  logic [CW-1:0]          umbral_high;
  logic [CW-1:0]          umbral_low;
  logic [NUM_DEST-1:0]    dest_almost_full;
  logic [NUM_DEST-1:0]    out_valid;
  logic [NUM_DEST*BW-1:0] out_data;
  logic [NUM_VC-1:0]      vc_almost_full;
  logic [NUM_VC-1:0]      vc_almost_empty;
  logic [NUM_VC-1:0]      vc_empty;
  logic                   error_output;

  qos_vc_router dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .arb_mode         (arb_mode),
    .vc_weight        (vc_weight),
    .umbral_high      (umbral_high),
    .umbral_low       (umbral_low),
    .dest_almost_full (dest_almost_full),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .vc_almost_full   (vc_almost_full),
    .vc_almost_empty  (vc_almost_empty),
    .vc_empty         (vc_empty),
    .error_output     (error_output)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [BW-1:0]       mq [NUM_VC][$];
  int                  m_ptr;
  int                  m_cred;
  logic                m_err;
  logic [NUM_DEST-1:0] m_valid;
  logic [BW-1:0]       m_data [NUM_DEST];
  logic [BW-1:0]       cap [$];

  int total = 0;
  int bad   = 0;

  function automatic logic [BW-1:0] mk(input int vc, input int dst, input int tag);
    return {VCW'(vc), DSTW'(dst), 2'(tag)};
  endfunction

  function automatic int effw(input int k);
    int w;
    w = int'(vc_weight[k*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int next_elig(input int from, input logic [NUM_VC-1:0] el);
    for (int i = 1; i <= NUM_VC; i++) begin
      if (el[(from + i) % NUM_VC]) return (from + i) % NUM_VC;
    end
    return -1;
  endfunction

  task automatic checkValue(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model after an edge.
  task automatic checkOutput();
    logic [NUM_DEST*BW-1:0] e_data;
    logic [NUM_VC-1:0]      e_empty, e_af, e_ae;
    logic                   e_ready;
    for (int d = 0; d < NUM_DEST; d++) e_data[d*BW +: BW] = m_data[d];
    for (int k = 0; k < NUM_VC; k++) begin
      e_empty[k] = (mq[k].size() == 0);
      e_af[k]    = (mq[k].size() >= int'(umbral_high));
      e_ae[k]    = (mq[k].size() <= int'(umbral_low));
    end
    e_ready = !reset && (e_af == '0);
    total++;
    assert (out_valid === m_valid) else begin
      bad++; $error("[TB] FAIL out_valid observed=%b expected=%b", out_valid, m_valid);
    end
    total++;
    assert (out_data === e_data) else begin
      bad++; $error("[TB] FAIL out_data observed=%h expected=%h", out_data, e_data);
    end
    total++;
    assert (vc_empty === e_empty) else begin
      bad++; $error("[TB] FAIL vc_empty observed=%b expected=%b", vc_empty, e_empty);
    end
    total++;
    assert (vc_almost_full === e_af) else begin
      bad++; $error("[TB] FAIL vc_almost_full observed=%b expected=%b", vc_almost_full, e_af);
    end
    total++;
    assert (vc_almost_empty === e_ae) else begin
      bad++; $error("[TB] FAIL vc_almost_empty observed=%b expected=%b", vc_almost_empty, e_ae);
    end
    total++;
    assert (in_ready === e_ready) else begin
      bad++; $error("[TB] FAIL in_ready observed=%b expected=%b", in_ready, e_ready);
    end
    total++;
    assert (error_output === m_err) else begin
      bad++; $error("[TB] FAIL error_output observed=%b expected=%b", error_output, m_err);
    end
  endtask

  // One clock: predict from the rules, advance, then check and capture.
  task automatic step();
    logic [NUM_VC-1:0] el;
    logic [BW-1:0]     din, pkt, hp;
    int                g, nptr, ncred, vc, hd;
    bit                rdy, acc, drop;
    rdy = (reset === 1'b0);
    for (int k = 0; k < NUM_VC; k++) begin
      if (mq[k].size() >= int'(umbral_high)) rdy = 0;
    end
    din  = in_data;
    acc  = (in_valid === 1'b1) && rdy;
    vc   = int'(din[BW-1 -: VCW]);
    drop = acc && (mq[vc].size() == VC_DEPTH);
    el = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      if (mq[k].size() > 0) begin
        hp = mq[k][0];
        hd = int'(hp[BW-1-VCW -: DSTW]);
        if (!dest_almost_full[hd]) el[k] = 1'b1;
      end
    end
    g = -1; nptr = m_ptr; ncred = m_cred;
    if (el != '0) begin
      if (arb_mode) begin
        for (int k = NUM_VC - 1; k >= 0; k--) if (el[k]) g = k;
      end else if (el[m_ptr]) begin
        g = m_ptr;
        ncred = m_cred + 1;
        if (ncred >= effw(m_ptr)) begin
          ncred = 0;
          nptr  = next_elig(m_ptr, el);
        end
      end else begin
        g = next_elig(m_ptr, el);
        nptr = g; ncred = 1;
        if (effw(g) <= 1) begin
          ncred = 0;
          nptr  = next_elig(g, el);
        end
      end
    end
    @(posedge clk);
    if (reset === 1'b1) begin
      for (int k = 0; k < NUM_VC; k++) mq[k].delete();
      m_ptr = 0; m_cred = 0; m_err = 1'b0; m_valid = '0;
      for (int d = 0; d < NUM_DEST; d++) m_data[d] = '0;
    end else begin
      m_valid = '0;
      if (g >= 0) begin
        pkt = mq[g].pop_front();
        hd  = int'(pkt[BW-1-VCW -: DSTW]);
        m_valid[hd] = 1'b1;
        m_data[hd]  = pkt;
      end
      if (acc) begin
        if (drop) m_err = 1'b1;
        else mq[vc].push_back(din);
      end
      m_ptr = nptr; m_cred = ncred;
    end
    #1;
    checkOutput();
    for (int d = 0; d < NUM_DEST; d++) begin
      if (out_valid[d] === 1'b1) cap.push_back(out_data[d*BW +: BW]);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [BW-1:0] d);
    in_valid = v;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic resetDut();
    reset = 1'b1; in_valid = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    int              lat;
    int              exp_order [$];
    logic [BW-1:0]   sent [$];
    logic [BW-1:0]   t;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; arb_mode = 1'b0;
    vc_weight = 16'h1112; umbral_high = 5'd12; umbral_low = 5'd2;
    dest_almost_full = '0;

    $display("[TB] reset state");
    resetDut();
    checkValue("reset_in_ready", int'(in_ready), 0);
    idle(1);

    $display("[TB] single packet latency");
    applyStimulus(1'b1, mk(1, 3, 2));
    lat = 1;
    while (out_valid == '0 && lat < 10) begin step(); lat++; end
    checkValue("latency", lat, 2);
    idle(2);

    $display("[TB] weighted round-robin order");
    resetDut();
    vc_weight = 16'h1112; dest_almost_full = 4'b0001;
    for (int v = 0; v < NUM_VC; v++)
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, mk(v, 0, i));
    cap.delete();
    dest_almost_full = '0;
    idle(40);
    for (int r = 0; r < 4; r++) begin
      exp_order.push_back(0); exp_order.push_back(0);
      exp_order.push_back(1); exp_order.push_back(2); exp_order.push_back(3);
    end
    for (int r = 0; r < 4; r++) begin
      exp_order.push_back(1); exp_order.push_back(2); exp_order.push_back(3);
    end
    checkValue("wrr_count", cap.size(), 32);
    for (int i = 0; i < exp_order.size(); i++) begin
      if (i < cap.size()) begin t = cap[i]; checkValue("wrr_vc", int'(t[BW-1 -: VCW]), exp_order[i]); end
      else checkValue("wrr_vc", -1, exp_order[i]);
    end

    $display("[TB] strict priority");
    resetDut();
    arb_mode = 1'b1; dest_almost_full = 4'b0010;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, mk(3, 1, i));
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, mk(1, 1, i));
    cap.delete();
    dest_almost_full = '0;
    idle(14);
    checkValue("strict_count", cap.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < cap.size()) begin t = cap[i]; checkValue("strict_vc", int'(t[BW-1 -: VCW]), (i < 5) ? 1 : 3); end
      else checkValue("strict_vc", -1, (i < 5) ? 1 : 3);
    end
    arb_mode = 1'b0;

    $display("[TB] destination backpressure");
    resetDut();
    dest_almost_full = 4'b0100;
    cap.delete();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, mk(0, 2, i));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, mk(1, 1, i));
    idle(3);
    dest_almost_full = '0;
    step();
    checkValue("bp_resume", int'(out_valid[2]), 1);
    idle(5);
    checkValue("bp_count", cap.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < cap.size()) checkValue("bp_order", int'(cap[i]), (i < 3) ? int'(mk(1, 1, i)) : int'(mk(0, 2, i - 3)));
      else checkValue("bp_order", -1, 0);
    end

    $display("[TB] overflow and thresholds");
    resetDut();
    umbral_high = 5'd20; dest_almost_full = 4'hF;
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, mk(2, i % 4, i % 4));
    checkValue("overflow_err", int'(error_output), 1);
    checkValue("overflow_full", int'(vc_empty[2]), 0);
    resetDut();
    umbral_high = 5'd12;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, mk(2, 3, i));
    checkValue("thresh_ready", int'(in_ready), 0);
    applyStimulus(1'b1, mk(2, 3, 1));
    dest_almost_full = '0;
    idle(16);

    $display("[TB] reset mid-stream");
    resetDut();
    dest_almost_full = 4'hF;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, mk(i % 4, 0, i));
    reset = 1'b1;
    step();
    checkValue("rst_empty", int'(vc_empty), 15);
    checkValue("rst_valid", int'(out_valid), 0);
    checkValue("rst_err", int'(error_output), 0);
    checkValue("rst_ready", int'(in_ready), 0);
    reset = 1'b0; dest_almost_full = '0;
    step();
    checkValue("post_rst_valid", int'(out_valid), 0);

    $display("[TB] streaming across pointer wrap");
    cap.delete();
    for (int i = 0; i < 40; i++) begin
      t = mk(3, 2, i % 4);
      sent.push_back(t);
      applyStimulus(1'b1, t);
    end
    idle(5);
    checkValue("wrap_count", cap.size(), 40);
    for (int i = 0; i < 40; i += 7) begin
      if (i < cap.size()) checkValue("wrap_data", int'(cap[i]), int'(sent[i]));
      else checkValue("wrap_data", -1, int'(sent[i]));
    end

    $display("[TB] randomized traffic");
    resetDut();
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 0) begin
        vc_weight   = NUM_VC*WW'($urandom);
        umbral_high = CW'($urandom_range(3, 18));
        umbral_low  = CW'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 9) == 0) arb_mode = ~arb_mode;
      dest_almost_full = NUM_DEST'($urandom & $urandom);
      applyStimulus(1'($urandom_range(0, 3) != 0), BW'($urandom));
    end
    dest_almost_full = '0;
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
